// File: rtl/param_dual_port_ram.sv
// True dual-port RAM with a power-on/reset clear sequencer and same-address write arbitration.
// Optional macro DPRAM_OUT_REG_EN adds one output register stage to dout_x/valid_x (read latency 2).
module param_dual_port_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din_a,
   input  logic [DATA_W-1:0] din_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic              re_a,
   input  logic              re_b,
   output logic [DATA_W-1:0] dout_a,
   output logic [DATA_W-1:0] dout_b,
   output logic              valid_a,
   output logic              valid_b,
   output logic              collision,
   output logic              busy
);

   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_e;

   state_e              state_q,     state_d;
   logic [ADDR_W-1:0]   clr_cnt_q,   clr_cnt_d;
   logic [DATA_W-1:0]   dout_a_q,    dout_a_d;
   logic [DATA_W-1:0]   dout_b_q,    dout_b_d;
   logic                valid_a_q,   valid_a_d;
   logic                valid_b_q,   valid_b_d;
   logic                collision_q, collision_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                ready;
   logic                same_addr;
   logic                wr_en_a;
   logic                wr_en_b;
   logic [ADDR_W-1:0]   wr_addr_a;
   logic [DATA_W-1:0]   wr_data_a;
   logic                rd_en_a;
   logic                rd_en_b;

   assign ready     = (state_q == ST_READY);
   assign same_addr = (addr_a == addr_b);

   // Write-port steering: the clear sequencer borrows port A; port B yields on an address tie.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      wr_en_a   = 1'b0;
      wr_addr_a = addr_a;
      wr_data_a = din_a;
      wr_en_b   = 1'b0;
      rd_en_a   = 1'b0;
      rd_en_b   = 1'b0;
      if (!ready) begin
         wr_en_a   = 1'b1;
         wr_addr_a = clr_cnt_q;
         wr_data_a = '0;
      end else begin
         wr_en_a = we_a;
         wr_en_b = we_b && !(we_a && same_addr);
         rd_en_a = re_a;
         rd_en_b = re_b;
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      dout_a_d    = dout_a_q;
      dout_b_d    = dout_b_q;
      valid_a_d   = 1'b0;
      valid_b_d   = 1'b0;
      collision_d = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == LAST_ADDR) begin
               state_d = ST_READY;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         ST_READY: begin
            // Reads sample the array before this edge's writes land, giving read-first behaviour.
            if (rd_en_a) begin
               dout_a_d  = mem[addr_a];
               valid_a_d = 1'b1;
            end
            if (rd_en_b) begin
               dout_b_d  = mem[addr_b];
               valid_b_d = 1'b1;
            end
            collision_d = we_a && we_b && same_addr;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_CLEAR;
         clr_cnt_q   <= '0;
         dout_a_q    <= '0;
         dout_b_q    <= '0;
         valid_a_q   <= 1'b0;
         valid_b_q   <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         dout_a_q    <= dout_a_d;
         dout_b_q    <= dout_b_d;
         valid_a_q   <= valid_a_d;
         valid_b_q   <= valid_b_d;
         collision_q <= collision_d;
      end
   end

   // NOTE: the array has no reset branch so it maps onto RAM macros; zeroing is the clear sequencer's job.
   always_ff @(posedge clk) begin
      if (wr_en_a) begin
         mem[wr_addr_a] <= wr_data_a;
      end
      if (wr_en_b) begin
         mem[addr_b] <= din_b;
      end
   end

`ifdef DPRAM_OUT_REG_EN
   logic [DATA_W-1:0] dout_a_s2_q,  dout_a_s2_d;
   logic [DATA_W-1:0] dout_b_s2_q,  dout_b_s2_d;
   logic              valid_a_s2_q, valid_a_s2_d;
   logic              valid_b_s2_q, valid_b_s2_d;

   always_comb begin
      dout_a_s2_d  = dout_a_q;
      dout_b_s2_d  = dout_b_q;
      valid_a_s2_d = valid_a_q;
      valid_b_s2_d = valid_b_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_a_s2_q  <= '0;
         dout_b_s2_q  <= '0;
         valid_a_s2_q <= 1'b0;
         valid_b_s2_q <= 1'b0;
      end else begin
         dout_a_s2_q  <= dout_a_s2_d;
         dout_b_s2_q  <= dout_b_s2_d;
         valid_a_s2_q <= valid_a_s2_d;
         valid_b_s2_q <= valid_b_s2_d;
      end
   end

   assign dout_a  = dout_a_s2_q;
   assign dout_b  = dout_b_s2_q;
   assign valid_a = valid_a_s2_q;
   assign valid_b = valid_b_s2_q;
`else
   assign dout_a  = dout_a_q;
   assign dout_b  = dout_b_q;
   assign valid_a = valid_a_q;
   assign valid_b = valid_b_q;
`endif

   assign collision = collision_q;
   assign busy      = (state_q == ST_CLEAR);

endmodule
